// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub -- pipelined carry-lookahead adder/subtractor.
//
// WIDTH-bit add/sub split into STAGES slices of WIDTH/STAGES bits. Each slice
// is built from GROUP-bit lookahead groups whose carries ripple inside the
// slice. Slot 0 registers the raw operands at acceptance. Slice k is evaluated
// from slot k and its result is registered into slot k+1. Slot STAGES is the
// output register, so the latency is STAGES cycles.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = out_ready | ~out_valid)
//   a, b, c, sub         operands, carry/borrow-in, 0 = add, 1 = subtract
//   out_valid/out_ready  result handshake
//   sum, carry           result and carry-out (for sub, 1 = no borrow)
//   ovf, zero            signed overflow and sum == 0
//
// Build option: define CLA_PIPE_FLAGS_EN to compute and register ovf/zero.
// Without it, both outputs are tied to 0.

// One slice: GROUP-bit lookahead groups with a rippled group carry.
module cla_slice #(
  parameter int SW    = 8,
  parameter int GROUP = 4
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o
);
  localparam int NG = SW / GROUP;

  logic [NG-1:0] grp_g, grp_p;
  logic [NG:0]   gc;

  // Group carries live in one block so the chain is a single ordered loop.
  always_comb begin
    gc[0] = cin_i;
    for (int g = 0; g < NG; g++) gc[g+1] = grp_g[g] | (grp_p[g] & gc[g]);
  end
  assign cout_o = gc[NG];

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [GROUP-1:0] p, gn, cb;
    assign p  = a_i[g*GROUP +: GROUP] ^ b_i[g*GROUP +: GROUP];
    assign gn = a_i[g*GROUP +: GROUP] & b_i[g*GROUP +: GROUP];

    // Group generate: carry out of the group when its carry-in is 0.
    always_comb begin
      grp_g[g] = 1'b0;
      for (int i = 0; i < GROUP; i++) grp_g[g] = gn[i] | (p[i] & grp_g[g]);
    end
    assign grp_p[g] = &p;

    // Bit carries inside the group, seeded by the group's incoming carry.
    always_comb begin
      cb[0] = gc[g];
      for (int i = 1; i < GROUP; i++) cb[i] = gn[i-1] | (p[i-1] & cb[i-1]);
    end
    assign sum_o[g*GROUP +: GROUP] = p ^ cb;
  end
endmodule

module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

  if (STAGES < 1 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a multiple of STAGES*GROUP, STAGES >= 1");
  end

  logic en;

  // Slot k: operands (b already inverted for sub), incoming carry of slice k,
  // and the sum bits finished so far. Only the operand bits above the
  // finished slices, plus the finished sum bits, are ever read. The dead bits
  // are removed when the netlist is optimized.
  logic [STAGES:0]    vld_q;
  logic [STAGES:0]    cy_q;
  logic [WIDTH-1:0]   a_q   [STAGES+1];
  logic [WIDTH-1:0]   b_q   [STAGES+1];
  logic [WIDTH-1:0]   sum_q [STAGES+1];
  logic [WIDTH-1:0]   sum_d [STAGES];   // next value of slot k+1

  logic [STAGES-1:0][SW-1:0] sl_s;
  logic [STAGES-1:0]         sl_co;

  // A stalled output freezes every slot, bubbles included, so order is kept.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_sl
    cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
      .a_i   (a_q[k][k*SW +: SW]),
      .b_i   (b_q[k][k*SW +: SW]),
      .cin_i (cy_q[k]),
      .sum_o (sl_s[k]),
      .cout_o(sl_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]              = sum_q[k];
      sum_d[k][k*SW +: SW]  = sl_s[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (en) begin
      vld_q    <= {vld_q[STAGES-1:0], in_valid};
      cy_q     <= {sl_co, c ^ sub};
      a_q[0]   <= a;
      b_q[0]   <= b ^ {WIDTH{sub}};
      sum_q[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k+1]   <= a_q[k];
        b_q[k+1]   <= b_q[k];
        sum_q[k+1] <= sum_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q[STAGES];
  assign carry     = cy_q[STAGES];

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q, zero_q, ovf_d;
  // Overflow judged on the top slice while its operands are still aligned.
  assign ovf_d = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                 (sl_s[STAGES-1][SW-1] != a_q[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      ovf_q  <= ovf_d;
      zero_q <= ~|sum_d[STAGES-1];
    end
  end
  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;
  localparam int W   = 32;
  localparam int STG = 4;
`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, c, sub, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          carry, ovf, zero;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4), .STAGES(STG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry, ovf, zero;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         c, sub;
    logic [W-1:0] sum;
    logic         carry, ovf, zero;
  } vec_t;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_out = 0, last_lat = 0;
  exp_t exp_q[$];
  int   emit_q[$];
  logic [W+2:0] last_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s, input int cy);
    exp_t e;
    longint unsigned ux, uy, t;
    longint sx, sy, sr;
    ux = 64'(x); uy = 64'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (!s) begin
      t = ux + uy + 64'(ci);
      e.carry = t[32];
      sr = sx + sy + longint'(ci);
    end else begin
      t = ux - uy - 64'(ci);
      e.carry = (ux >= uy + 64'(ci));
      sr = sx - sy - longint'(ci);
    end
    e.sum  = t[31:0];
    e.ovf  = FLAGS && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    e.zero = FLAGS && (e.sum == '0);
    e.cyc  = cy;
    return e;
  endfunction

  // Monitor: samples 2 time units after each falling edge, i.e. after the
  // driver has settled; transfers then take effect on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        emit_q.push_back(cyc);
        last_out = {sum, carry, ovf, zero};
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_lat = cyc - e.cyc - 1;
          chk("sb_result", {sum, carry, ovf, zero}, {e.sum, e.carry, e.ovf, e.zero});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c, sub, cyc));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; c = ci; sub = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_nout(input int target, input int bound, input string nm);
    int k = 0;
    while (n_out < target && k < bound) begin
      @(negedge clk); #3; k++;
    end
    chk(nm, n_out, target);
  endtask

  vec_t tbl[8];

  initial begin
    int base, k;
    logic acc;
    logic [W+2:0] held;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_valid, sum, carry, ovf, zero}, '0);
    rst = 1'b0;
    #1 chk("reset_in_ready", in_ready, 1);

    // Directed vectors, one at a time through an empty pipe.
    for (int i = 0; i < 8; i++) begin
      base = n_out;
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub);
      wait_nout(base + 1, 20, "vec_count");
      chk($sformatf("vec%0d_latency", i), last_lat, STG);
      chk($sformatf("vec%0d_out", i), last_out,
          {tbl[i].sum, tbl[i].carry, FLAGS & tbl[i].ovf, FLAGS & tbl[i].zero});
    end

    // Back-to-back stream of 8 random beats.
    base = n_out; emit_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      c = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk); in_valid = 1'b0;
    wait_nout(base + 8, 30, "stream_count");
    chk("stream_latency", last_lat, STG);
    if (emit_q.size() == 8)
      for (int i = 1; i < 8; i++) chk("stream_gap", emit_q[i] - emit_q[i-1], 1);

    // Stall: fill with 4 beats, block the output, then release.
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; c = 1'b0; sub = 1'(i);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); #3; k++; end
    chk("stall_valid", out_valid, 1);
    held = {sum, carry, ovf, zero};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", {out_valid, sum, carry, ovf, zero}, {1'b1, held});
    end
    @(negedge clk); out_ready = 1'b1;
    wait_nout(base + 4, 20, "stall_count");
    chk("stall_drained", exp_q.size(), 0);

    // Reset while two beats are in flight.
    base = n_out;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; c = 1'b1; sub = 1'b0;
    end
    @(negedge clk); rst = 1'b1; a = 32'h55AA55AA; b = 32'h0F0F0F0F;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = 1'b0;
    #1 chk("midreset_outputs", {out_valid, sum, carry, ovf, zero}, '0);
    repeat (10) @(negedge clk);
    #3 chk("midreset_no_stale", n_out, base);
    send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    wait_nout(base + 1, 20, "post_reset_count");
    chk("post_reset_latency", last_lat, STG);
    chk("post_reset_sum", last_out[W+2:3], 32'h00000030);

    // Random traffic with random back-pressure.
    acc = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        c = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1 acc = in_valid && in_ready;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin @(negedge clk); #3; k++; end
    chk("random_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. It extends the 4-bit lookahead cell to WIDTH bits in GROUP-bit lookahead groups, split across STAGES register slices. It uses a valid/ready handshake and provides optional status flags. It sits in the datapath wherever a wide add/sub must close timing at full clock rate, with one result per cycle.

## Interface
- WIDTH, 32, operand/result width in bits
- GROUP, 4, bits per lookahead group; generate/propagate computed per group, group carries ripple within a slice
- STAGES, 4, pipeline slices; slice k handles bits [k*WIDTH/STAGES +: WIDTH/STAGES]; WIDTH % (STAGES*GROUP) must be 0, STAGES >= 1, else elaboration error

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = a+b+c, 1 = a-b-c
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- carry  out  1  carry-out of final group; for sub, 1 = no borrow
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

## Operation
- Effective operands: b_eff = b ^ {WIDTH{sub}}, cin = c ^ sub. The result is a + b_eff + cin, truncated to WIDTH, with carry = bit WIDTH.
- Per group: p = a^b_eff, g = a&b_eff, group carry-out = g | p&cin bitwise-chained. Sum bit = p ^ incoming carry.
- Slice k computes its bits in cycle k after acceptance, using the carry registered out of slice k-1. Slice 0 uses cin.
- Unprocessed upper operand slices travel in skew registers. Completed lower sum slices travel in deskew registers. All bits of a result leave together.
- One valid bit per slot; the pipeline is a shift register of STAGES slots.
- Global advance: en = out_ready | ~out_valid, and in_ready = en.
  - When en=0, every slot holds, including bubbles.
  - When en=1, every slot shifts one position and slot 0 loads {in_valid, operands}.
- Handshake: a beat transfers on in_valid & in_ready, and on out_valid & out_ready. Results emerge strictly in acceptance order, with no loss or duplication.
- ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), evaluated on the aligned operands of the final slice.
- zero = ~|sum.

## Timing
- Latency: exactly STAGES cycles from the accepting edge to out_valid when no stall occurs; each stall cycle adds one.
- Throughput: 1 result/cycle while out_ready=1.
- All outputs are registered. in_ready is combinational from out_ready and out_valid.
- While out_valid=1 and out_ready=0, sum/carry/ovf/zero are held stable and in_ready=0.
- Reset: out_valid=0, sum=0, carry=0, ovf=0, zero=0, and all valid bits, skew data and inter-slice carries are cleared. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and none emerge afterwards. rst dominates in_valid in the same cycle.
- Simultaneous accept and emit with en=1 is the normal steady state; the slot count is unchanged.
- STAGES=1: the full-width lookahead is computed in one cycle with latency 1.

## Configuration
- CLA_PIPE_FLAGS_EN defined:
  - ovf and zero are computed and registered alongside sum, as above.
- CLA_PIPE_FLAGS_EN undefined:
  - ovf and zero are tied to 0 and no flag logic or registers exist.
  - sum, carry, the handshake and latency are identical to the defined build.

## Test plan
- Add 0xFFFFFFFF + 0x00000001, c=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000000, carry=1, zero=1, ovf=0.
- Sub 0x00000005 - 0x00000007, c=0 -> sum=0xFFFFFFFE, carry=0, ovf=0, zero=0. Sub 7-5 -> sum=0x00000002, carry=1.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, carry=0. With the macro undefined -> same sum, ovf=0.
- Stream 8 random beats back-to-back with out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle 4, matching the reference a±b±c, in order.
- Hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs stable. Then release -> remaining results follow in order with no loss or duplication.
- Accept 2 beats, assert rst for 1 cycle -> next cycle out_valid=0 and all outputs 0. No stale result ever appears, and a new beat returns after 4 cycles.
